enemy_mover: RTL

Parametrised grid-sweep enemy movement engine. On each `start`, and only after a configurable move period has elapsed, it scans the tile grid in row-major order. Each enemy tile gets at most one step into an adjacent air tile. The first direction tried comes from an LFSR or, in chase mode, points toward the player; up to four directions are tried. It sits between the game-tick sequencer (`start`/`done`) and the single-port tile-grid RAM, which has a 1-cycle registered read.

---
 rtl/enemy_pkg.sv | 34 +++
 rtl/enemy_dir_pick.sv | 51 +++++
 rtl/enemy_mover.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy movement engine.
// Holds the direction and FSM state enums plus the LFSR seed/taps and step
// function used by the direction picker.
package enemy_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GATE,
    ST_SCAN_ADDR,
    ST_SCAN_CHK,
    ST_TRY_ADDR,
    ST_TRY_CHK,
    ST_WRITE_NEW,
    ST_ERASE_OLD,
    ST_ADVANCE,
    ST_DONE
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 in right-shifting Galois form.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/enemy_dir_pick.sv
// First-direction picker: free-running 8-bit LFSR plus chase/random selection.
// Ports: clock/reset, chase mode, scan cell x/y, player_x/player_y in;
// d0 (first direction to try) out, combinational from the current inputs.
module enemy_dir_pick
  import enemy_pkg::*;
#(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      chase,
  input  logic [$clog2(GRID_W)-1:0] x,
  input  logic [$clog2(GRID_H)-1:0] y,
  input  logic [$clog2(GRID_W)-1:0] player_x,
  input  logic [$clog2(GRID_H)-1:0] player_y,
  output dir_t                      d0
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int AW = (XW > YW) ? XW : YW;

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb lfsr_d = lfsr_step(lfsr_q);

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  logic [AW-1:0] px, py, xx, yy, adx, ady;

  always_comb begin
    px  = AW'(player_x);
    py  = AW'(player_y);
    xx  = AW'(x);
    yy  = AW'(y);
    // Magnitudes kept unsigned; the sign is recovered from the comparisons.
    adx = (px >= xx) ? px - xx : xx - px;
    ady = (py >= yy) ? py - yy : yy - py;
    d0  = dir_t'(lfsr_q[1:0]);
    if (chase) begin
      if ((adx >= ady) && (adx != '0)) d0 = (px > xx) ? DIR_RIGHT : DIR_LEFT;
      else if (ady != '0)              d0 = (py > yy) ? DIR_DOWN : DIR_UP;
    end
  end

endmodule

// File: rtl/enemy_mover.sv
// Grid-sweep enemy mover: row-major scan, at most one step per enemy per sweep.
// Ports: start/done/busy handshake with the tick sequencer, chase + player
// position in, single-port tile RAM (grid_x/y, grid_out, grid_write, grid_in), moves out.
module enemy_mover
  import enemy_pkg::*;
#(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int CELL_W      = 3,
  parameter int ENEMY_CODE  = 4,
  parameter int AIR_CODE    = 0,
  parameter int MOVE_PERIOD = 200000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 chase,
  input  logic [$clog2(GRID_W)-1:0]            player_x,
  input  logic [$clog2(GRID_H)-1:0]            player_y,
  output logic [$clog2(GRID_W)-1:0]            grid_x,
  output logic [$clog2(GRID_H)-1:0]            grid_y,
  input  logic [CELL_W-1:0]                    grid_out,
  output logic                                 grid_write,
  output logic [CELL_W-1:0]                    grid_in,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]   moves
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int MW = $clog2(GRID_W*GRID_H+1);
  localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [TW-1:0]     TIMER_INIT = TW'(MOVE_PERIOD - 1);
  localparam logic [CELL_W-1:0] ENEMY      = CELL_W'(ENEMY_CODE);
  localparam logic [CELL_W-1:0] AIR        = CELL_W'(AIR_CODE);

  state_t            state_q, state_d;
  logic [XW-1:0]     scan_x_q, scan_x_d;
  logic [YW-1:0]     scan_y_q, scan_y_d;
  logic [1:0]        try_q, try_d;
  dir_t              d0_q, d0_d;
  logic [GRID_W-1:0] cur_mask_q, cur_mask_d;
  logic [GRID_W-1:0] next_mask_q, next_mask_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              en_q, en_d;
  logic              chase_q, chase_d;
  logic [MW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     moves_q, moves_d;

  dir_t          pick_d0;
  dir_t          dir;
  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic          cand_ok;
  logic          last_x, last_y;

  enemy_dir_pick #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_dir_pick (
    .clock    (clock),
    .reset    (reset),
    .chase    (chase_q),
    .x        (scan_x_q),
    .y        (scan_y_q),
    .player_x (player_x),
    .player_y (player_y),
    .d0       (pick_d0)
  );

  assign last_x = (scan_x_q == XW'(GRID_W - 1));
  assign last_y = (scan_y_q == YW'(GRID_H - 1));
  assign dir    = dir_t'(d0_q + try_q);

  // Candidate neighbour; cand_ok is false whenever the step would leave the grid.
  always_comb begin
    cand_x  = scan_x_q;
    cand_y  = scan_y_q;
    cand_ok = 1'b0;
    case (dir)
      DIR_UP:    begin cand_ok = (scan_y_q != '0); cand_y = scan_y_q - YW'(1); end
      DIR_RIGHT: begin cand_ok = !last_x;          cand_x = scan_x_q + XW'(1); end
      DIR_DOWN:  begin cand_ok = !last_y;          cand_y = scan_y_q + YW'(1); end
      default:   begin cand_ok = (scan_x_q != '0); cand_x = scan_x_q - XW'(1); end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    scan_x_d    = scan_x_q;
    scan_y_d    = scan_y_q;
    try_d       = try_q;
    d0_d        = d0_q;
    cur_mask_d  = cur_mask_q;
    next_mask_d = next_mask_q;
    en_d        = en_q;
    chase_d     = chase_q;
    cnt_d       = cnt_q;
    moves_d     = moves_q;
    timer_d     = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    case (state_q)
      ST_IDLE: if (start) begin
        chase_d = chase;
        state_d = ST_GATE;
      end
      ST_GATE: if (timer_q == '0) begin
        en_d        = 1'b1;
        scan_x_d    = '0;
        scan_y_d    = '0;
        cur_mask_d  = '0;
        next_mask_d = '0;
        cnt_d       = '0;
        state_d     = ST_SCAN_ADDR;
      end else begin
        en_d    = 1'b0;
        state_d = ST_DONE;
      end
      ST_SCAN_ADDR: state_d = ST_SCAN_CHK;
      ST_SCAN_CHK: if ((grid_out == ENEMY) && !cur_mask_q[scan_x_q]) begin
        try_d   = 2'd0;
        d0_d    = pick_d0;
        state_d = ST_TRY_ADDR;
      end else begin
        state_d = ST_ADVANCE;
      end
      ST_TRY_ADDR: if (cand_ok)           state_d = ST_TRY_CHK;
                   else if (try_q == 2'd3) state_d = ST_ADVANCE;
                   else                    try_d   = try_q + 2'd1;
      ST_TRY_CHK: if (grid_out == AIR)     state_d = ST_WRITE_NEW;
                  else if (try_q == 2'd3)  state_d = ST_ADVANCE;
                  else begin
                    try_d   = try_q + 2'd1;
                    state_d = ST_TRY_ADDR;
                  end
      ST_WRITE_NEW: begin
        cnt_d = cnt_q + MW'(1);
        // Right/down moves land in cells still ahead of the scan: mark them.
        if (dir == DIR_RIGHT) cur_mask_d[cand_x]   = 1'b1;
        if (dir == DIR_DOWN)  next_mask_d[scan_x_q] = 1'b1;
        state_d = ST_ERASE_OLD;
      end
      ST_ERASE_OLD: state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        if (last_x && last_y) begin
          moves_d = cnt_q;
          state_d = ST_DONE;
        end else begin
          if (last_x) begin
            scan_x_d    = '0;
            scan_y_d    = scan_y_q + YW'(1);
            cur_mask_d  = next_mask_q;
            next_mask_d = '0;
          end else begin
            scan_x_d = scan_x_q + XW'(1);
          end
          state_d = ST_SCAN_ADDR;
        end
      end
      ST_DONE: begin
        if (en_q) timer_d = TIMER_INIT;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      try_q       <= '0;
      d0_q        <= DIR_UP;
      cur_mask_q  <= '0;
      next_mask_q <= '0;
      timer_q     <= TIMER_INIT;
      en_q        <= 1'b0;
      chase_q     <= 1'b0;
      cnt_q       <= '0;
      moves_q     <= '0;
    end else begin
      state_q     <= state_d;
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      try_q       <= try_d;
      d0_q        <= d0_d;
      cur_mask_q  <= cur_mask_d;
      next_mask_q <= next_mask_d;
      timer_q     <= timer_d;
      en_q        <= en_d;
      chase_q     <= chase_d;
      cnt_q       <= cnt_d;
      moves_q     <= moves_d;
    end
  end

  // RAM mux: out-of-bounds candidates leave the address at 0.
  always_comb begin
    grid_x     = '0;
    grid_y     = '0;
    grid_write = 1'b0;
    grid_in    = '0;
    case (state_q)
      ST_SCAN_ADDR, ST_SCAN_CHK: begin
        grid_x = scan_x_q;
        grid_y = scan_y_q;
      end
      ST_TRY_ADDR, ST_TRY_CHK: if (cand_ok) begin
        grid_x = cand_x;
        grid_y = cand_y;
      end
      ST_WRITE_NEW: begin
        grid_x     = cand_x;
        grid_y     = cand_y;
        grid_write = 1'b1;
        grid_in    = ENEMY;
      end
      ST_ERASE_OLD: begin
        grid_x     = scan_x_q;
        grid_y     = scan_y_q;
        grid_write = 1'b1;
        grid_in    = AIR;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign moves = moves_q;

endmodule
